// File: rtl/n101_qspi_shift_engine_pkg.sv
// Shared definitions for the QSPI shift engine: protocol codes, FSM states and
// beat-width helpers used to pick and shift the data lanes.
package n101_qspi_defines;

    localparam logic [1:0] PROTO_SINGLE = 2'd0;
    localparam logic [1:0] PROTO_DUAL   = 2'd1;
    localparam logic [1:0] PROTO_QUAD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Protocol code 3 is not defined and falls back to single-lane width.
    function automatic logic [2:0] beat_width(input logic [1:0] proto);
        case (proto)
            PROTO_DUAL: return 3'd2;
            PROTO_QUAD: return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] beat_out(input logic [7:0] sr, input logic [1:0] proto,
                                            input logic endian);
        case (beat_width(proto))
            3'd2:    return endian ? {2'b00, sr[1:0]} : {2'b00, sr[7:6]};
            3'd4:    return endian ? sr[3:0] : sr[7:4];
            default: return endian ? {3'b000, sr[0]} : {3'b000, sr[7]};
        endcase
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic [3:0] din,
                                            input logic [1:0] proto, input logic endian);
        case (beat_width(proto))
            3'd2:    return endian ? {din[1:0], sr[7:2]} : {sr[5:0], din[1:0]};
            3'd4:    return endian ? {din[3:0], sr[7:4]} : {sr[3:0], din[3:0]};
            default: return endian ? {din[0], sr[7:1]} : {sr[6:0], din[0]};
        endcase
    endfunction

    // Single lane runs full duplex, so its output lane is enabled whatever the direction.
    function automatic logic [3:0] oe_mask(input logic [1:0] proto, input logic iodir);
        case (beat_width(proto))
            3'd2:    return iodir ? 4'b0011 : 4'b0000;
            3'd4:    return iodir ? 4'b1111 : 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/n101_qspi_shift_engine_sck_div.sv
// SCK half-period generator: a down-counter that ticks every load_value+1 clocks
// and restarts from the new divider value when a frame starts.
module n101_qspi_sck_div #(
    parameter int DIV_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] load_value,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || (count == '0)) begin
            count <= load_value;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = !restart && (count == '0);

endmodule

// File: rtl/n101_qspi_shift_engine.sv
// QSPI physical-layer shift engine: serialises one link frame per request onto
// SCK/CS/DQ and returns the shifted-in byte on the link rx channel.
module n101_qspi_shift_engine
    import n101_qspi_defines::*;
#(
    parameter int   DIV_W   = 12,
    parameter logic CS_IDLE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] ctrl_sck_div,
    input  logic             ctrl_sck_pol,
    input  logic             ctrl_sck_pha,
    input  logic             link_tx_valid,
    input  logic [7:0]       link_tx_bits,
    output logic             link_tx_ready,
    input  logic [7:0]       link_cnt,
    input  logic [1:0]       link_fmt_proto,
    input  logic             link_fmt_endian,
    input  logic             link_fmt_iodir,
    input  logic             link_cs_set,
    input  logic             link_cs_clear,
    input  logic             link_cs_hold,
    input  logic             link_lock,
    output logic             link_rx_valid,
    output logic [7:0]       link_rx_bits,
    output logic             link_active,
    output logic             sck,
    output logic             cs_n,
    output logic [3:0]       dq_o,
    output logic [3:0]       dq_oe,
    input  logic [3:0]       dq_i
);

    state_t           state, state_next;
    logic [DIV_W-1:0] div_q;
    logic             pol_q, pha_q, endian_q, iodir_q, cs_clear_q;
    logic [1:0]       proto_q;
    logic [3:0]       cnt_q, cnt_sat;
    logic [4:0]       hp_idx, hp_last;
    logic [7:0]       sr, sr_next;
    logic [3:0]       din;
    logic             fire, tick, cs_asserted, sample_edge, enter_hold;
    logic             unused_inputs;

    assign unused_inputs = ^{link_lock, link_cnt[7:4]};

    assign fire          = link_tx_valid && (state == ST_IDLE);
    assign link_tx_ready = (state == ST_IDLE);
    assign link_active   = (state != ST_IDLE);
    assign cs_asserted   = (cs_n != CS_IDLE);
    assign cnt_sat       = (link_cnt[3:0] > 4'd8) ? 4'd8 : link_cnt[3:0];
    assign hp_last       = {cnt_q, 1'b0} - 5'd1;

    n101_qspi_sck_div #(.DIV_W(DIV_W)) u_sck_div (
        .clock      (clock),
        .reset      (reset),
        .restart    (fire),
        .load_value (fire ? ctrl_sck_div : div_q),
        .tick       (tick)
    );

    // Even half-periods end on the leading SCK edge; CPHA picks which edge samples.
    assign din         = (beat_width(proto_q) == 3'd1) ? {3'b000, dq_i[1]} : dq_i;
    assign sample_edge = tick && (state == ST_SHIFT) && (hp_idx[0] == pha_q);
    assign sr_next     = sample_edge ? shift_in(sr, din, proto_q, endian_q) : sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dq_oe      = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    if (!cs_asserted && link_cs_set) state_next = ST_SETUP;
                    else if (cnt_sat == 4'd0)        state_next = ST_HOLD;
                    else                             state_next = ST_SHIFT;
                end
            end
            ST_SETUP: begin
                dq_oe = oe_mask(proto_q, iodir_q);
                if (tick) state_next = (cnt_q == 4'd0) ? ST_HOLD : ST_SHIFT;
            end
            ST_SHIFT: begin
                dq_oe = oe_mask(proto_q, iodir_q);
                if (tick && (hp_idx == hp_last)) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        enter_hold = (state_next == ST_HOLD) && (state != ST_HOLD);
    end

    // Frame configuration is captured at fire and stays frozen until the next fire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            pol_q         <= 1'b0;
            pha_q         <= 1'b0;
            proto_q       <= PROTO_SINGLE;
            endian_q      <= 1'b0;
            iodir_q       <= 1'b0;
            cnt_q         <= 4'd0;
            cs_clear_q    <= 1'b0;
            sr            <= 8'h00;
            hp_idx        <= 5'd0;
            sck           <= 1'b0;
            cs_n          <= CS_IDLE;
            dq_o          <= 4'b0000;
            link_rx_valid <= 1'b0;
            link_rx_bits  <= 8'h00;
        end else begin
            link_rx_valid <= enter_hold;
            if (enter_hold) link_rx_bits <= fire ? link_tx_bits : sr_next;

            if (fire) begin
                div_q      <= ctrl_sck_div;
                pol_q      <= ctrl_sck_pol;
                pha_q      <= ctrl_sck_pha;
                proto_q    <= link_fmt_proto;
                endian_q   <= link_fmt_endian;
                iodir_q    <= link_fmt_iodir;
                cnt_q      <= cnt_sat;
                cs_clear_q <= link_cs_clear;
                sr         <= link_tx_bits;
                hp_idx     <= 5'd0;
                sck        <= ctrl_sck_pol;
                if (link_cs_set)   cs_n <= ~CS_IDLE;
                if (!ctrl_sck_pha) dq_o <= beat_out(link_tx_bits, link_fmt_proto, link_fmt_endian);
            end else begin
                sr <= sr_next;
                if (state == ST_SHIFT) begin
                    if (tick) begin
                        sck    <= ~sck;
                        hp_idx <= hp_idx + 5'd1;
                        if (!hp_idx[0]) dq_o <= beat_out(sr_next, proto_q, endian_q);
                    end
                end else begin
                    sck <= pol_q;
                end
                if ((state == ST_HOLD) && tick && cs_clear_q && !link_cs_hold) cs_n <= CS_IDLE;
                if ((state == ST_IDLE) && cs_asserted && link_cs_clear && !link_cs_hold) cs_n <= CS_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_n101_qspi_shift_engine.sv
// Self-checking bench for n101_qspi_shift_engine: directed and random frames
// compared against a byte/beat-level model of the serialiser and CS behaviour.
module tb_n101_qspi_shift_engine;

    localparam int DIV_W = 12;

    logic             clock = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] ctrl_sck_div;
    logic             ctrl_sck_pol, ctrl_sck_pha;
    logic             link_tx_valid, link_tx_ready;
    logic [7:0]       link_tx_bits, link_cnt, link_rx_bits;
    logic [1:0]       link_fmt_proto;
    logic             link_fmt_endian, link_fmt_iodir;
    logic             link_cs_set, link_cs_clear, link_cs_hold, link_lock;
    logic             link_rx_valid, link_active, sck, cs_n;
    logic [3:0]       dq_o, dq_oe, dq_i, dq_drv;
    logic             loop_mode;

    int n_checks = 0;
    int n_fail   = 0;
    bit cs_low_model = 1'b0;

    always #5 clock = ~clock;

    assign dq_i = loop_mode ? {2'b00, dq_o[0], 1'b0} : dq_drv;

    n101_qspi_shift_engine #(.DIV_W(DIV_W), .CS_IDLE(1'b1)) dut (
        .clock           (clock),
        .reset           (reset),
        .ctrl_sck_div    (ctrl_sck_div),
        .ctrl_sck_pol    (ctrl_sck_pol),
        .ctrl_sck_pha    (ctrl_sck_pha),
        .link_tx_valid   (link_tx_valid),
        .link_tx_bits    (link_tx_bits),
        .link_tx_ready   (link_tx_ready),
        .link_cnt        (link_cnt),
        .link_fmt_proto  (link_fmt_proto),
        .link_fmt_endian (link_fmt_endian),
        .link_fmt_iodir  (link_fmt_iodir),
        .link_cs_set     (link_cs_set),
        .link_cs_clear   (link_cs_clear),
        .link_cs_hold    (link_cs_hold),
        .link_lock       (link_lock),
        .link_rx_valid   (link_rx_valid),
        .link_rx_bits    (link_rx_bits),
        .link_active     (link_active),
        .sck             (sck),
        .cs_n            (cs_n),
        .dq_o            (dq_o),
        .dq_oe           (dq_oe),
        .dq_i            (dq_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Put one receive beat on the lanes the protocol samples; the other lanes carry noise.
    task automatic driveDq(input int val, input int w);
        logic [3:0] rnd;
        rnd = 4'($urandom);
        if (w == 1)      dq_drv = {rnd[3:2], val[0], rnd[0]};
        else if (w == 2) dq_drv = {rnd[3:2], val[1:0]};
        else             dq_drv = val[3:0];
    endtask

    task automatic applyStimulus(input int div, input int pol, input int pha, input int proto,
                                 input int endian, input int iodir, input int cnt, input int tx,
                                 input int cs_set, input int cs_clear, input int cs_hold,
                                 input int loop, input int use_fixed, input int fixed_in);
        int  w, ecnt, sr, exp_rx, lmask, exp_oe, g, c, edges, last_c, first_lat, bad_iv, bad_dq, b;
        int  outb[8];
        int  inb[8];
        bit  setup;
        logic       prev_sck;
        logic [3:0] prev_dq;

        w     = (proto == 1) ? 2 : (proto == 2) ? 4 : 1;
        lmask = (1 << w) - 1;
        ecnt  = ((cnt & 15) > 8) ? 8 : (cnt & 15);
        sr    = tx & 255;
        for (int i = 0; i < 8; i++) begin
            outb[i] = 0;
            inb[i]  = 0;
        end
        for (int i = 0; i < ecnt; i++) begin
            outb[i] = (endian != 0) ? (sr & lmask) : (sr >> (8 - w));
            inb[i]  = (use_fixed != 0) ? ((fixed_in >> (4 * i)) & lmask) : int'($urandom_range(0, lmask));
            if (loop != 0) inb[i] = outb[i];
            sr = (endian != 0) ? ((sr >> w) | (inb[i] << (8 - w))) : (((sr << w) | inb[i]) & 255);
        end
        exp_rx = sr;
        setup  = !cs_low_model && (cs_set != 0);
        exp_oe = (w == 1) ? 1 : ((iodir != 0) ? lmask : 0);

        @(negedge clock);
        g = 0;
        while (!link_tx_ready && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (g >= 100) checkOutput("ready_timeout", 0, 1);
        ctrl_sck_div    = DIV_W'(div);
        ctrl_sck_pol    = pol[0];
        ctrl_sck_pha    = pha[0];
        link_fmt_proto  = proto[1:0];
        link_fmt_endian = endian[0];
        link_fmt_iodir  = iodir[0];
        link_cnt        = cnt[7:0];
        link_tx_bits    = tx[7:0];
        link_cs_set     = cs_set[0];
        link_cs_clear   = cs_clear[0];
        link_cs_hold    = cs_hold[0];
        loop_mode       = loop[0];
        link_lock       = 1'b1;
        link_tx_valid   = 1'b1;
        driveDq(inb[0], w);
        @(negedge clock);
        link_tx_valid   = 1'b0;
        link_cs_set     = 1'b0;
        link_cs_clear   = 1'b0;
        link_lock       = 1'b0;
        ctrl_sck_div    = DIV_W'($urandom);
        ctrl_sck_pol    = 1'($urandom);
        ctrl_sck_pha    = 1'($urandom);
        link_fmt_proto  = 2'($urandom);
        link_fmt_endian = 1'($urandom);
        link_fmt_iodir  = 1'($urandom);
        link_cnt        = 8'($urandom);

        checkOutput("sck_start", sck, pol);
        checkOutput("cs_start", cs_n, (cs_low_model || cs_set != 0) ? 0 : 1);
        checkOutput("oe_frame", dq_oe, (setup || ecnt > 0) ? exp_oe : 0);
        if (cs_set != 0) cs_low_model = 1'b1;

        c = 1; edges = 0; last_c = 0; first_lat = -1; bad_iv = 0; bad_dq = 0;
        while (!link_rx_valid && c < 3000) begin
            prev_sck = sck;
            prev_dq  = dq_o;
            @(negedge clock);
            c++;
            if (sck !== prev_sck) begin
                edges++;
                if (edges == 1) first_lat = c - 1;
                else if (c - last_c != div + 1) bad_iv++;
                last_c = c;
                if ((pha != 0) ? (edges % 2 == 0) : (edges % 2 == 1)) begin
                    b = (edges - 1) / 2;
                    if (b < 8) begin
                        if ((int'(prev_dq) & lmask) != outb[b]) bad_dq++;
                        if (b + 1 < ecnt) driveDq(inb[b + 1], w);
                    end else begin
                        bad_dq++;
                    end
                end
            end
        end
        if (!link_rx_valid) begin
            checkOutput("rx_timeout", 0, 1);
            return;
        end
        checkOutput("rx_bits", link_rx_bits, exp_rx);
        checkOutput("sck_edges", edges, 2 * ecnt);
        checkOutput("rx_latency", c - 1, ((setup ? 1 : 0) + 2 * ecnt) * (div + 1));
        if (ecnt > 0) begin
            checkOutput("first_edge", first_lat, (setup ? 2 : 1) * (div + 1));
            checkOutput("half_period", bad_iv, 0);
            checkOutput("dq_o_beats", bad_dq, 0);
        end
        checkOutput("sck_hold", sck, pol);
        checkOutput("cs_hold_phase", cs_n, cs_low_model ? 0 : 1);

        @(negedge clock);
        checkOutput("rx_pulse", link_rx_valid, 0);
        repeat (div) @(negedge clock);
        if (cs_clear != 0 && cs_hold == 0) cs_low_model = 1'b0;
        checkOutput("cs_after", cs_n, cs_low_model ? 0 : 1);
        checkOutput("idle_active", {link_active, link_tx_ready}, 2'b01);
        checkOutput("idle_oe", dq_oe, 0);
        link_cs_hold = 1'b0;
        loop_mode    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int rx_count;
        reset = 1'b1;
        ctrl_sck_div = '0; ctrl_sck_pol = 1'b0; ctrl_sck_pha = 1'b0;
        link_tx_valid = 1'b0; link_tx_bits = 8'h00; link_cnt = 8'h00;
        link_fmt_proto = 2'd0; link_fmt_endian = 1'b0; link_fmt_iodir = 1'b0;
        link_cs_set = 1'b0; link_cs_clear = 1'b0; link_cs_hold = 1'b0; link_lock = 1'b0;
        dq_drv = 4'h0; loop_mode = 1'b0;
        #12;
        checkOutput("reset_pins", {sck, cs_n, dq_o, dq_oe}, 10'b0_1_0000_0000);
        checkOutput("reset_link", {link_tx_ready, link_rx_valid, link_active, link_rx_bits}, 11'b100_00000000);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed frames");
        applyStimulus(0, 0, 0, 0, 0, 1, 8, 'hA5, 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 2, 0, 1, 2, 'h3C, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2, 1, 0, 2, 'h5A, 1, 1, 0, 0, 1, 'h69);
        applyStimulus(1, 0, 0, 1, 0, 1, 4, 'h96, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 1, 4, 'h1E, 1, 1, 0, 0, 0, 0);
        applyStimulus(3, 1, 1, 0, 0, 1, 8, 'hC7, 1, 1, 0, 0, 0, 0);
        applyStimulus(2, 0, 0, 0, 0, 1, 0, 'hC3, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 2, 0, 1, 12, 'h81, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 1, 0, 5, 'h4B, 0, 0, 0, 0, 0, 0);

        $display("[TB] idle chip-select release");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 'h01, 1, 0, 0, 0, 0, 0);
        @(negedge clock);
        link_cs_clear = 1'b1; link_cs_hold = 1'b1;
        @(negedge clock);
        checkOutput("idle_clear_held", cs_n, 0);
        link_cs_hold = 1'b0;
        @(negedge clock);
        link_cs_clear = 1'b0;
        checkOutput("idle_clear", cs_n, 1);
        cs_low_model = 1'b0;

        $display("[TB] random frames");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 1 : 0, 0, 0, 0);
        end

        $display("[TB] reset during shift");
        @(negedge clock);
        ctrl_sck_div = 12'd1; ctrl_sck_pol = 1'b0; ctrl_sck_pha = 1'b0;
        link_fmt_proto = 2'd2; link_fmt_iodir = 1'b1; link_cnt = 8'd8; link_tx_bits = 8'hE7;
        link_cs_set = 1'b1; link_cs_clear = 1'b1; link_tx_valid = 1'b1;
        @(negedge clock);
        link_tx_valid = 1'b0; link_cs_set = 1'b0; link_cs_clear = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("pre_reset_active", link_active, 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_pins", {sck, cs_n, dq_oe}, 6'b0_1_0000);
        checkOutput("mid_reset_link", {link_tx_ready, link_rx_valid, link_active}, 3'b100);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cs_low_model = 1'b0;
        rx_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (link_rx_valid) rx_count++;
        end
        checkOutput("no_rx_after_reset", rx_count, 0);
        checkOutput("ready_after_reset", {link_tx_ready, cs_n}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
